// File: rtl/or8_rr_sched_pkg.sv
// Shared definitions for the round-robin OR scheduler: datapath width,
// default requester count, index-width helper and the slot-state encoding.
package or8_rr_sched_pkg;

  // The shared OR unit is fixed at 8 bits wide.
  localparam int OR_W     = 8;
  localparam int NREQ_DEF = 4;

  // Width needed to index n items. Never returns less than 1, so a
  // 2-requester build still has a 1-bit index.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // One-entry response slot state.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_e;

endpackage

// File: rtl/or8_rr_sched_rr_pick.sv
// Combinational round-robin picker: scans valid starting at ptr and
// wrapping through N-1 back to 0, returning the first hit as a one-hot
// grant and as an encoded index. Holds no state, so other schedulers can
// reuse it.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   i_valid,
  input  logic [IDW-1:0] i_ptr,
  output logic [N-1:0]   o_grant,
  output logic [IDW-1:0] o_idx,
  output logic           o_any
);

  // Priority scan from ptr. The wrap subtracts N explicitly, so the scan
  // is correct when N is not a power of two.
  always_comb begin
    int j;
    j       = 0;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(i_ptr) + k;
      if (j >= N) j = j - N;
      if (!o_any && i_valid[j]) begin
        o_any      = 1'b1;
        o_grant[j] = 1'b1;
        o_idx      = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/org8.sv
// Existing 8-bit bitwise OR unit shared by the scheduler.
module org8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);

  assign y = a | b;

endmodule

// File: rtl/or8_rr_sched.sv
// Round-robin scheduler sharing one org8 OR unit among NREQ requesters.
// Each cycle one winner is granted, its x|y goes into a one-entry
// registered response slot, and the slot is tagged with the winner's index.
module or8_rr_sched
  import or8_rr_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = OR_W,
  parameter int IDW  = clog2(NREQ),
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_x,
  input  logic [NREQ*W-1:0] req_y,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  output logic [W-1:0]      rsp_data,
  output logic [IDW-1:0]    rsp_id,
  input  logic              rsp_ready,
  output logic [CNTW-1:0]   op_count
);

  slot_e             r_state;
  slot_e             w_state_nxt;
  logic [IDW-1:0]    r_ptr;
  logic [W-1:0]      r_rsp_data;
  logic [IDW-1:0]    r_rsp_id;
  logic [CNTW-1:0]   r_op_count;

  logic              w_slot_free;
  logic [NREQ-1:0]   w_grant;
  logic [IDW-1:0]    w_idx;
  logic              w_any;
  logic              w_xfer;
  logic [W-1:0]      w_x;
  logic [W-1:0]      w_y;
  logic [W-1:0]      w_or;

  // The slot can accept a new result if it is empty or is being drained.
  assign w_slot_free = (r_state == SLOT_EMPTY) || rsp_ready;

  rr_pick #(
    .N   (NREQ),
    .IDW (IDW)
  ) u_pick (
    .i_valid (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Grants are suppressed while the slot is stalled and while reset is
  // asserted, so nothing is granted during reset.
  assign req_ready = w_grant & {NREQ{w_slot_free & rst_n}};
  assign w_xfer    = w_any & w_slot_free & rst_n;

  // Operand mux onto the single shared OR unit.
  assign w_x = req_x[w_idx*W +: W];
  assign w_y = req_y[w_idx*W +: W];

  org8 u_or (
    .a (w_x),
    .b (w_y),
    .y (w_or)
  );

  // Slot state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= SLOT_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Slot next state: fill on transfer, drain when consumed with no refill.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SLOT_EMPTY: if (w_xfer)                w_state_nxt = SLOT_FULL;
      SLOT_FULL:  if (rsp_ready && !w_xfer)  w_state_nxt = SLOT_EMPTY;
      default:                               w_state_nxt = SLOT_EMPTY;
    endcase
  end

  // Capture the result and advance priority past the winner on each
  // transfer. Idle cycles leave ptr alone, so priority does not rotate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_data <= '0;
      r_rsp_id   <= '0;
      r_ptr      <= '0;
    end else if (w_xfer) begin
      r_rsp_data <= w_or;
      r_rsp_id   <= w_idx;
      r_ptr      <= (w_idx == IDW'(NREQ-1)) ? '0 : w_idx + IDW'(1);
    end
  end

  // Accepted-operation counter; wraps silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_op_count <= '0;
    else if (w_xfer) r_op_count <= r_op_count + CNTW'(1);
  end

  assign rsp_valid = (r_state == SLOT_FULL);
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign op_count  = r_op_count;

endmodule

// File: tb/tb_or8_rr_sched.sv
// Self-checking bench for or8_rr_sched. A second instance with a 4-bit
// counter shares all inputs so that counter wrap can be observed. The
// reference model keeps the slot contents, rotating priority and count
// as plain integers.
module tb_or8_rr_sched;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_x;
  logic [NREQ*W-1:0] req_y;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [W-1:0]      rsp_data;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_ready;
  logic [15:0]       op_count;

  logic [NREQ-1:0]   req_ready2;
  logic              rsp_valid2;
  logic [W-1:0]      rsp_data2;
  logic [IDW-1:0]    rsp_id2;
  logic [3:0]        op_count2;

  or8_rr_sched #(.NREQ(NREQ), .W(W), .IDW(IDW), .CNTW(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_x(req_x),
    .req_y(req_y), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_ready(rsp_ready),
    .op_count(op_count)
  );

  or8_rr_sched #(.NREQ(NREQ), .W(W), .IDW(IDW), .CNTW(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_x(req_x),
    .req_y(req_y), .req_ready(req_ready2), .rsp_valid(rsp_valid2),
    .rsp_data(rsp_data2), .rsp_id(rsp_id2), .rsp_ready(rsp_ready),
    .op_count(op_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  int          m_ptr;
  int          m_valid;
  int          m_data;
  int          m_id;
  int unsigned m_cnt;
  int          m_win;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_valid = 0; m_data = 0; m_id = 0; m_cnt = 0; m_win = -1;
  endtask

  // Winner = first valid requester at or after ptr, circularly, provided
  // the slot is empty or being drained.
  task automatic calc_win();
    int j;
    m_win = -1;
    if (m_valid == 0 || rsp_ready) begin
      for (int k = 0; k < NREQ; k++) begin
        j = (m_ptr + k) % NREQ;
        if (m_win < 0 && req_valid[j]) m_win = j;
      end
    end
  endtask

  function automatic logic [7:0] opx(input int i);
    logic [NREQ*W-1:0] v;
    v = req_x;
    return v[i*W +: W];
  endfunction

  function automatic logic [7:0] opy(input int i);
    logic [NREQ*W-1:0] v;
    v = req_y;
    return v[i*W +: W];
  endfunction

  // One clock: check grant before the edge, advance model, check outputs.
  task automatic step();
    logic [NREQ-1:0] exp_rdy;
    #1;
    calc_win();
    exp_rdy = '0;
    if (m_win >= 0) exp_rdy[m_win] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    @(posedge clk);
    if (m_win >= 0) begin
      m_data  = int'(opx(m_win) | opy(m_win));
      m_id    = m_win;
      m_valid = 1;
      m_ptr   = (m_win + 1) % NREQ;
      m_cnt   = m_cnt + 1;
    end else if (rsp_ready) begin
      m_valid = 0;
    end
    #1;
    chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    if (m_valid != 0) begin
      chk("rsp_data", 32'(rsp_data), 32'(m_data));
      chk("rsp_id",   32'(rsp_id),   32'(m_id));
    end
    chk("op_count",  32'(op_count),  m_cnt % 65536);
    chk("op_count4", 32'(op_count2), m_cnt % 16);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_op_count",  32'(op_count),  0);
    chk("rst_rsp_data",  32'(rsp_data),  0);
    chk("rst_rsp_id",    32'(rsp_id),    0);
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic set_op(input int i, input logic [7:0] x, input logic [7:0] y);
    req_x[i*W +: W] = x;
    req_y[i*W +: W] = y;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_x = '0; req_y = '0; rsp_ready = 1'b1;
    model_reset();

    // 1. Reset then idle.
    do_reset();
    step();
    step();

    // 2. Single requester.
    req_valid = 4'b0100;
    set_op(2, 8'hA0, 8'h05);
    step();
    chk("t2_data", 32'(rsp_data), 32'h A5);
    chk("t2_id",   32'(rsp_id),   2);
    chk("t2_cnt",  32'(op_count), 1);
    req_valid = '0;
    step();

    // 3. All requesters held, one result per cycle in rotating order.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, 8'(i), 8'h10);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t3_id",   32'(rsp_id),   k % NREQ);
      chk("t3_data", 32'(rsp_data), 32'h10 + (k % NREQ));
    end

    // 4. Backpressure holds the slot and blocks all grants.
    do_reset();
    req_valid = 4'b0001;
    set_op(0, 8'hF0, 8'h0F);
    step();
    for (int i = 0; i < NREQ; i++) set_op(i, 8'h20 + 8'(i), 8'h01);
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t4_hold_data", 32'(rsp_data), 32'h FF);
      chk("t4_hold_id",   32'(rsp_id),   0);
    end
    rsp_ready = 1'b1;
    step();
    chk("t4_next_id",   32'(rsp_id),   1);
    chk("t4_next_data", 32'(rsp_data), 32'h21);

    // 5. Asynchronous reset mid-operation.
    do_reset();
    req_valid = 4'b0100;
    set_op(2, 8'h3C, 8'h00);
    step();
    req_valid = 4'b1010;
    set_op(1, 8'h40, 8'h02);
    set_op(3, 8'h80, 8'h04);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_rsp_valid", 32'(rsp_valid), 0);
    chk("t5_rsp_data",  32'(rsp_data),  0);
    chk("t5_op_count",  32'(op_count),  0);
    chk("t5_req_ready", 32'(req_ready), 0);
    model_reset();
    #2;
    rst_n = 1'b1;
    step();
    chk("t5_first_id", 32'(rsp_id), 1);
    req_valid = 4'b1000;
    step();
    req_valid = '0;
    step();

    // 6. Counter wrap on the 4-bit instance.
    do_reset();
    req_valid = 4'b0001;
    set_op(0, 8'h11, 8'h22);
    for (int k = 1; k <= 17; k++) begin
      step();
      if (k == 15) chk("t6_cnt15", 32'(op_count2), 15);
      if (k == 16) chk("t6_cnt16", 32'(op_count2), 0);
      if (k == 17) chk("t6_cnt17", 32'(op_count2), 1);
    end

    // Random traffic; requesters hold valid and operands until granted.
    do_reset();
    req_valid = '0;
    for (int n = 0; n < 400; n++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          req_valid[i] = 1'b1;
          set_op(i, 8'($urandom), 8'($urandom));
        end
      end
      step();
      if (m_win >= 0) req_valid[m_win] = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
